// File: rtl/axi_stream_pckg.sv
// Shared constants, FSM state type and beat-select helper for the FFT output stream master.
package axi_stream_pckg;

    localparam int VLW_WDT           = 64;
    localparam int C_FFT_SIZE_LOG2   = 12;
    localparam int OUTPUT_MEM_OFFSET = 0;
    localparam int M_TDATA_WDT       = 32;
    localparam int M_FIFO_SIZE       = 16;
    localparam int M_FIFO_ADDR_WDT   = $clog2(M_FIFO_SIZE);
    localparam int M_IF_BUFFER_SIZE  = VLW_WDT / M_TDATA_WDT;
    localparam int M_FRAME_WORDS     = 2 ** C_FFT_SIZE_LOG2;
    localparam int M_PACKET_CNT      = M_FRAME_WORDS * M_IF_BUFFER_SIZE;
    localparam int M_PACKET_CNT_WDT  = $clog2(M_PACKET_CNT);
    localparam int M_FIFO_WR_FINAL   = M_FIFO_SIZE - 1;
    localparam int M_BEAT_IDX_WDT    = (M_IF_BUFFER_SIZE > 1) ? $clog2(M_IF_BUFFER_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Beat 0 is the least-significant slice of the memory word.
    function automatic logic [M_TDATA_WDT-1:0] beat_select(
        input logic [VLW_WDT-1:0]        word,
        input logic [M_BEAT_IDX_WDT-1:0] idx
    );
        return word[int'(idx)*M_TDATA_WDT +: M_TDATA_WDT];
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with full/empty flags; the head entry is presented from register storage
// and forced to zero while empty so the stream data reads 0 when nothing is valid.
module axis_sync_fifo #(
    parameter int WIDTH    = 33,
    parameter int DEPTH    = 16,
    parameter int ADDR_WDT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam logic [ADDR_WDT-1:0] PTR_LAST  = ADDR_WDT'(DEPTH - 1);
    localparam logic [ADDR_WDT:0]   CNT_FULL  = (ADDR_WDT + 1)'(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [ADDR_WDT-1:0] wr_ptr;
    logic [ADDR_WDT-1:0] rd_ptr;
    logic [ADDR_WDT:0]   count;
    logic                do_rd;
    logic                do_wr;

    function automatic logic [ADDR_WDT-1:0] next_ptr(input logic [ADDR_WDT-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + ADDR_WDT'(1);
    endfunction

    always_comb begin
        full  = (count == CNT_FULL);
        empty = (count == '0);
        do_rd = rd_en && !empty;
        // A write into a full FIFO is accepted when the same cycle frees a slot.
        do_wr = wr_en && (!full || do_rd);
    end

    always_comb begin
        rd_data = '0;
        if (!empty) begin
            rd_data = mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_rd) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (ADDR_WDT + 1)'(1);
                2'b01:   count <= count - (ADDR_WDT + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axis_fft_out_master.sv
// Streams one FFT frame from the output memory onto an AXI4-Stream master port:
// memory read (p1) -> word serializer (p2) -> beat FIFO -> m_axis.
module axis_fft_out_master
    import axi_stream_pckg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       mem_rd_en,
    output logic [C_FFT_SIZE_LOG2-1:0] mem_rd_addr,
    input  logic [VLW_WDT-1:0]         mem_rd_data,
    output logic [M_TDATA_WDT-1:0]     m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast
);

    localparam logic [C_FFT_SIZE_LOG2:0]    WORDS_TOTAL = (C_FFT_SIZE_LOG2 + 1)'(M_FRAME_WORDS);
    localparam logic [C_FFT_SIZE_LOG2:0]    WORD_LAST   = (C_FFT_SIZE_LOG2 + 1)'(M_FRAME_WORDS - 1);
    localparam logic [M_BEAT_IDX_WDT-1:0]   BEAT_LAST   = M_BEAT_IDX_WDT'(M_IF_BUFFER_SIZE - 1);
    localparam logic [M_PACKET_CNT_WDT-1:0] PACKET_LAST = M_PACKET_CNT_WDT'(M_PACKET_CNT - 1);

    state_t                      state;
    state_t                      state_nxt;
    logic [C_FFT_SIZE_LOG2:0]    rd_cnt;
    logic                        vld_p1;
    logic [VLW_WDT-1:0]          word_p2;
    logic                        vld_p2;
    logic [M_BEAT_IDX_WDT-1:0]   beat_idx_p2;
    logic [M_PACKET_CNT_WDT-1:0] beat_cnt_p2;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [M_TDATA_WDT:0]        fifo_wr_data;
    logic [M_TDATA_WDT:0]        fifo_rd_data;
    logic                        frame_start;
    logic                        words_left;
    logic                        push;
    logic                        emit_last;
    logic                        rd_issue;
    logic                        last_read;
    logic                        last_hs;

    always_comb begin
        frame_start = (state == IDLE) && start;
        words_left  = (rd_cnt != WORDS_TOTAL);
        push        = vld_p2 && !fifo_full;
        emit_last   = push && (beat_idx_p2 == BEAT_LAST);
        // One read in flight at most, and only when the serializer can take the word next cycle.
        rd_issue    = (state == READ) && !vld_p1 && (!vld_p2 || emit_last) && words_left;
        last_read   = rd_issue && (rd_cnt == WORD_LAST);
        last_hs     = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = READ;
            READ:    if (last_read) state_nxt = DRAIN;
            DRAIN:   if (last_hs)   state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        mem_rd_en = rd_issue;
    end

    // p0 -> p1: read issue and address generation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt      <= '0;
            mem_rd_addr <= C_FFT_SIZE_LOG2'(OUTPUT_MEM_OFFSET);
            vld_p1      <= 1'b0;
        end else begin
            vld_p1 <= rd_issue;
            if (frame_start) begin
                rd_cnt      <= '0;
                mem_rd_addr <= C_FFT_SIZE_LOG2'(OUTPUT_MEM_OFFSET);
            end else if (rd_issue) begin
                rd_cnt      <= rd_cnt + (C_FFT_SIZE_LOG2 + 1)'(1);
                mem_rd_addr <= mem_rd_addr + C_FFT_SIZE_LOG2'(1);
            end
        end
    end

    // p1 -> p2: capture returned word into the serializer
    always_ff @(posedge clk) begin
        if (vld_p1) begin
            word_p2 <= mem_rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2      <= 1'b0;
            beat_idx_p2 <= '0;
            beat_cnt_p2 <= '0;
        end else begin
            if (vld_p1) begin
                vld_p2      <= 1'b1;
                beat_idx_p2 <= '0;
            end else if (emit_last) begin
                vld_p2      <= 1'b0;
                beat_idx_p2 <= '0;
            end else if (push) begin
                beat_idx_p2 <= beat_idx_p2 + M_BEAT_IDX_WDT'(1);
            end
            if (frame_start) begin
                beat_cnt_p2 <= '0;
            end else if (push) begin
                beat_cnt_p2 <= beat_cnt_p2 + M_PACKET_CNT_WDT'(1);
            end
        end
    end

    // p2 -> FIFO: one {tlast, tdata} entry per pushed beat
    always_comb begin
        fifo_wr_data = {(beat_cnt_p2 == PACKET_LAST), beat_select(word_p2, beat_idx_p2)};
    end

    axis_sync_fifo #(
        .WIDTH   (M_TDATA_WDT + 1),
        .DEPTH   (M_FIFO_SIZE),
        .ADDR_WDT(M_FIFO_ADDR_WDT)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (push),
        .wr_data(fifo_wr_data),
        .rd_en  (m_axis_tready),
        .rd_data(fifo_rd_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        m_axis_tvalid = !fifo_empty;
        m_axis_tlast  = fifo_rd_data[M_TDATA_WDT];
        m_axis_tdata  = fifo_rd_data[M_TDATA_WDT-1:0];
    end

endmodule

// File: tb/tb_axis_fft_out_master.sv
// Directed bench for axis_fft_out_master: memory model, per-scenario tasks with inline checks.
module tb_axis_fft_out_master;

    localparam int BUDGET = 40000;

    typedef struct {
        int          beats;
        int          bad;
        int          first_bad;
        logic [31:0] bad_got;
        logic [31:0] bad_want;
        logic [31:0] first_data;
        int          tlast_cnt;
        int          tlast_bad;
        int          done_cnt;
        int          done_cyc;
        int          last_hs;
        int          first_rd;
        int          first_addr;
        int          first_vld;
        int          reads;
        int          stall_reads;
        int          stable_err;
        int          vld_at_release;
        int          timeout;
    } stats_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [11:0] mem_rd_addr;
    logic [63:0] mem_rd_data;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    int passed = 0;
    int total  = 0;

    axis_fft_out_master dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .m_axis_tdata (tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tlast (tlast)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= {32'hA000_0000 + 32'(mem_rd_addr), 32'h5000_0000 + 32'(mem_rd_addr)};
        end
    end

    function automatic logic [31:0] exp_beat(input int j);
        int k;
        int w;
        k = j % 8192;
        w = k / 2;
        return (k % 2 == 1) ? 32'hA000_0000 + 32'(w) : 32'h5000_0000 + 32'(w);
    endfunction

    // mode 0: tready=1, 1: tready=0 for the first 100 cycles, 2: random tready.
    task automatic drive_frame(input int mode, input bit poke, input int frames,
                               input int abort_beats, output stats_t s);
        int          n = 0;
        int          j = 0;
        int          chain_at = -1;
        int          poke_at = -1;
        int          tail = -1;
        bit          pend = 1'b0;
        logic [31:0] pdata = '0;
        logic        plast = 1'b0;
        s = '{default: 0};
        s.first_bad  = -1;
        s.done_cyc   = -1;
        s.last_hs    = -1;
        s.first_rd   = -1;
        s.first_addr = -1;
        s.first_vld  = -1;
        @(negedge clk);
        while (n < BUDGET) begin
            start = (n == 0) || (n == chain_at) || (poke && (n == 10 || n == poke_at));
            case (mode)
                0:       tready = 1'b1;
                1:       tready = (n >= 100);
                default: tready = 1'($urandom_range(0, 1));
            endcase
            if (mem_rd_en) begin
                if (s.first_rd < 0) begin
                    s.first_rd   = n;
                    s.first_addr = int'(mem_rd_addr);
                end
                s.reads++;
                if (n < 100) s.stall_reads++;
                if (s.reads == 4096 && poke_at < 0) poke_at = n + 1;
            end
            if (pend && (!tvalid || tdata !== pdata || tlast !== plast)) s.stable_err++;
            if (tvalid && s.first_vld < 0) begin
                s.first_vld  = n;
                s.first_data = tdata;
            end
            if (n == 99) s.vld_at_release = int'(tvalid);
            if (tvalid && tready) begin
                if (tdata !== exp_beat(j)) begin
                    if (s.bad == 0) begin
                        s.first_bad = j;
                        s.bad_got   = tdata;
                        s.bad_want  = exp_beat(j);
                    end
                    s.bad++;
                end
                if (tlast) s.tlast_cnt++;
                if (tlast !== ((j % 8192) == 8191)) s.tlast_bad++;
                s.last_hs = n;
                j++;
                s.beats++;
            end
            pend  = tvalid && !tready;
            pdata = tdata;
            plast = tlast;
            if (done) begin
                s.done_cnt++;
                if (s.done_cyc < 0) s.done_cyc = n;
                if (s.done_cnt < frames) chain_at = n + 1;
                else if (tail < 0) tail = 20;
            end
            if (abort_beats > 0 && s.beats >= abort_beats) break;
            if (tail == 0) break;
            if (tail > 0) tail--;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (n >= BUDGET) s.timeout = 1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        start  = 1'b0;
        tready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        tready = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        total++; if (mem_rd_en !== 1'b0) $display("FAIL reset_rd_en got %b want 0", mem_rd_en); else passed++;
        total++; if (mem_rd_addr !== 12'h000) $display("FAIL reset_addr got %h want 000", mem_rd_addr); else passed++;
        total++; if (tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", tvalid); else passed++;
        total++; if (tlast !== 1'b0) $display("FAIL reset_tlast got %b want 0", tlast); else passed++;
        total++; if (tdata !== 32'h0) $display("FAIL reset_tdata got %h want 00000000", tdata); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        stats_t s;
        drive_frame(0, 1'b0, 1, 0, s);
        total++; if (s.timeout !== 0) $display("FAIL basic_timeout got %0d want 0", s.timeout); else passed++;
        total++; if (s.beats !== 8192) $display("FAIL basic_beats got %0d want 8192", s.beats); else passed++;
        total++; if (s.bad !== 0) $display("FAIL basic_data errors=%0d want 0 (beat %0d got %h want %h)", s.bad, s.first_bad, s.bad_got, s.bad_want); else passed++;
        total++; if (s.tlast_cnt !== 1) $display("FAIL basic_tlast_cnt got %0d want 1", s.tlast_cnt); else passed++;
        total++; if (s.tlast_bad !== 0) $display("FAIL basic_tlast_pos errors=%0d want 0", s.tlast_bad); else passed++;
        total++; if (s.first_rd !== 1) $display("FAIL basic_first_rd got %0d want 1", s.first_rd); else passed++;
        total++; if (s.first_addr !== 0) $display("FAIL basic_first_addr got %0d want 0", s.first_addr); else passed++;
        total++; if (s.first_vld !== 4) $display("FAIL basic_first_tvalid got %0d want 4", s.first_vld); else passed++;
        total++; if (s.first_data !== 32'h5000_0000) $display("FAIL basic_first_data got %h want 50000000", s.first_data); else passed++;
        total++; if (s.done_cyc !== s.last_hs + 1) $display("FAIL basic_done_cycle got %0d want %0d", s.done_cyc, s.last_hs + 1); else passed++;
        total++; if (s.done_cnt !== 1) $display("FAIL basic_done_cnt got %0d want 1", s.done_cnt); else passed++;
        total++; if (s.reads !== 4096) $display("FAIL basic_reads got %0d want 4096", s.reads); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL basic_busy_after got %b want 0", busy); else passed++;
    endtask

    task automatic test_backpressure();
        stats_t s;
        drive_frame(1, 1'b0, 1, 200, s);
        total++; if (s.stall_reads !== 9) $display("FAIL bp_stall_reads got %0d want 9", s.stall_reads); else passed++;
        total++; if (s.vld_at_release !== 1) $display("FAIL bp_tvalid_held got %0d want 1", s.vld_at_release); else passed++;
        total++; if (s.stable_err !== 0) $display("FAIL bp_stable errors=%0d want 0", s.stable_err); else passed++;
        total++; if (s.beats !== 200) $display("FAIL bp_beats got %0d want 200", s.beats); else passed++;
        total++; if (s.bad !== 0) $display("FAIL bp_data errors=%0d want 0 (beat %0d got %h want %h)", s.bad, s.first_bad, s.bad_got, s.bad_want); else passed++;
        apply_reset();
    endtask

    task automatic test_random_ready();
        stats_t s;
        drive_frame(2, 1'b0, 1, 0, s);
        total++; if (s.timeout !== 0) $display("FAIL rand_timeout got %0d want 0", s.timeout); else passed++;
        total++; if (s.beats !== 8192) $display("FAIL rand_beats got %0d want 8192", s.beats); else passed++;
        total++; if (s.bad !== 0) $display("FAIL rand_data errors=%0d want 0 (beat %0d got %h want %h)", s.bad, s.first_bad, s.bad_got, s.bad_want); else passed++;
        total++; if (s.stable_err !== 0) $display("FAIL rand_stable errors=%0d want 0", s.stable_err); else passed++;
        total++; if (s.tlast_bad !== 0) $display("FAIL rand_tlast_pos errors=%0d want 0", s.tlast_bad); else passed++;
        total++; if (s.done_cnt !== 1) $display("FAIL rand_done_cnt got %0d want 1", s.done_cnt); else passed++;
    endtask

    task automatic test_start_ignored();
        stats_t s;
        drive_frame(0, 1'b1, 1, 0, s);
        total++; if (s.beats !== 8192) $display("FAIL restart_beats got %0d want 8192", s.beats); else passed++;
        total++; if (s.bad !== 0) $display("FAIL restart_data errors=%0d want 0 (beat %0d got %h want %h)", s.bad, s.first_bad, s.bad_got, s.bad_want); else passed++;
        total++; if (s.done_cnt !== 1) $display("FAIL restart_done_cnt got %0d want 1", s.done_cnt); else passed++;
        total++; if (s.reads !== 4096) $display("FAIL restart_reads got %0d want 4096", s.reads); else passed++;
        total++; if (s.tlast_cnt !== 1) $display("FAIL restart_tlast_cnt got %0d want 1", s.tlast_cnt); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL restart_busy_after got %b want 0", busy); else passed++;
    endtask

    task automatic test_mid_reset();
        stats_t s;
        int     zero_err = 0;
        int     idle_err = 0;
        drive_frame(0, 1'b0, 1, 3000, s);
        total++; if (s.beats !== 3000) $display("FAIL mrst_pre_beats got %0d want 3000", s.beats); else passed++;
        rst_n  = 1'b0;
        tready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if ({busy, done, mem_rd_en, tvalid, tlast} !== 5'b0 || tdata !== 32'h0) zero_err++;
        end
        total++; if (zero_err !== 0) $display("FAIL mrst_outputs_zero errors=%0d want 0", zero_err); else passed++;
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (tvalid || busy || mem_rd_en) idle_err++;
        end
        total++; if (idle_err !== 0) $display("FAIL mrst_no_beats errors=%0d want 0", idle_err); else passed++;
        drive_frame(0, 1'b0, 1, 64, s);
        total++; if (s.first_addr !== 0) $display("FAIL mrst_first_addr got %0d want 0", s.first_addr); else passed++;
        total++; if (s.first_data !== 32'h5000_0000) $display("FAIL mrst_first_data got %h want 50000000", s.first_data); else passed++;
        total++; if (s.first_vld !== 4) $display("FAIL mrst_first_tvalid got %0d want 4", s.first_vld); else passed++;
        total++; if (s.bad !== 0) $display("FAIL mrst_data errors=%0d want 0 (beat %0d got %h want %h)", s.bad, s.first_bad, s.bad_got, s.bad_want); else passed++;
        apply_reset();
    endtask

    task automatic test_back_to_back();
        stats_t s;
        drive_frame(0, 1'b0, 2, 0, s);
        total++; if (s.timeout !== 0) $display("FAIL b2b_timeout got %0d want 0", s.timeout); else passed++;
        total++; if (s.beats !== 16384) $display("FAIL b2b_beats got %0d want 16384", s.beats); else passed++;
        total++; if (s.bad !== 0) $display("FAIL b2b_data errors=%0d want 0 (beat %0d got %h want %h)", s.bad, s.first_bad, s.bad_got, s.bad_want); else passed++;
        total++; if (s.tlast_cnt !== 2) $display("FAIL b2b_tlast_cnt got %0d want 2", s.tlast_cnt); else passed++;
        total++; if (s.tlast_bad !== 0) $display("FAIL b2b_tlast_pos errors=%0d want 0", s.tlast_bad); else passed++;
        total++; if (s.done_cnt !== 2) $display("FAIL b2b_done_cnt got %0d want 2", s.done_cnt); else passed++;
        total++; if (s.reads !== 8192) $display("FAIL b2b_reads got %0d want 8192", s.reads); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_random_ready();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
